// File: rtl/fwd_operand_mux_pipe.sv
// Operand-forwarding N:1 mux feeding a 2-entry valid/ready skid buffer.
// Selects one of NUM_SRC WIDTH-bit candidates by in_sel and registers the result
// so the consumer sees a timing-clean operand. Out-of-range selects produce a
// zero operand tagged with out_oob and are counted in a saturating error counter.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   flush           drop every buffered entry and any input offered this cycle
//   in_valid/ready  upstream handshake; in_ready is registered
//   in_sel          source index; in_data packs source k at [k*WIDTH +: WIDTH]
//   out_valid/ready downstream handshake
//   out_data        selected operand; out_oob marks an out-of-range select
//   err_sticky      set by any accepted out-of-range select until reset
//   err_count       saturating count of accepted out-of-range selects
module fwd_operand_mux_pipe #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [$clog2(NUM_SRC)-1:0]     in_sel,
    input  logic [NUM_SRC*WIDTH-1:0]       in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_oob,
    output logic                           err_sticky,
    output logic [CNT_W-1:0]               err_count
);

    localparam int unsigned SEL_W = $clog2(NUM_SRC);
    // With a power-of-two source count every select value is a real source.
    localparam bit IS_POW2 = ((32'd1 << SEL_W) == NUM_SRC);
    localparam logic [SEL_W:0] NUM_SRC_V = (SEL_W+1)'(NUM_SRC);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] s_data;
    logic             s_oob;

    logic [WIDTH-1:0] sel_data_c;
    logic             sel_oob_c;
    logic             accept_c;
    logic             emit_c;

    // Source selection; unmatched (out-of-range) selects leave the zero default.
    always_comb begin
        sel_data_c = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data_c = in_data[k*WIDTH +: WIDTH];
            end
        end
        sel_oob_c = 1'b0;
        if (!IS_POW2) begin
            sel_oob_c = ({1'b0, in_sel} >= NUM_SRC_V);
        end
    end

    // An input offered during flush is discarded, so it never counts as accepted.
    assign accept_c = in_valid && in_ready && !flush;
    assign emit_c   = out_valid && out_ready;

    // Buffer state machine: M (out_data/out_oob) is the head, S holds the overflow entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_EMPTY;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_oob    <= 1'b0;
            s_data     <= '0;
            s_oob      <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (accept_c && sel_oob_c) begin
                err_sticky <= 1'b1;
                if (err_count != {CNT_W{1'b1}}) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
            case (state)
                ST_EMPTY: begin
                    if (accept_c) begin
                        out_data  <= sel_data_c;
                        out_oob   <= sel_oob_c;
                        out_valid <= 1'b1;
                        state     <= ST_FULL1;
                    end
                end
                ST_FULL1: begin
                    if (accept_c && emit_c) begin
                        out_data <= sel_data_c;
                        out_oob  <= sel_oob_c;
                    end else if (accept_c) begin
                        s_data   <= sel_data_c;
                        s_oob    <= sel_oob_c;
                        in_ready <= 1'b0;
                        state    <= ST_FULL2;
                    end else if (emit_c) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_FULL2: begin
                    if (emit_c) begin
                        out_data <= s_data;
                        out_oob  <= s_oob;
                        in_ready <= 1'b1;
                        state    <= ST_FULL1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
